// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the 8-bit CPU sequencer: opcodes, FSM states and ALU operations.
package cpu_seq_pkg;

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_FETCH_IMM = 3'd3,
    ST_EXEC      = 3'd4,
    ST_MEM       = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  // ALU opcodes travel unchanged from IR[6:4] to alu_op.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  function automatic logic [3:0] opcode_of(input logic [7:0] insn);
    return insn[7:4];
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction classifier: maps an 8-bit instruction byte to its control class.
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [7:0] insn,
  output logic       is_alu,
  output logic       is_ld,
  output logic       is_st,
  output logic       needs_imm,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_ldi,
  output logic       is_hlt
);

  logic [3:0] op;

  assign op        = opcode_of(insn);
  assign is_alu    = ~op[3];
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_jz     = (op == OP_JZ);
  assign is_jmp    = (op == OP_JMP);
  assign is_ldi    = (op == OP_LDI);
  assign is_hlt    = (op == OP_HLT);
  assign needs_imm = is_jz | is_jmp | is_ldi;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control FSM for the 8-bit CPU; owns PC, IR and Z/C flags.
// Define CPU_SEQ_TRACE_EN to add the retire/retire_pc instruction trace outputs.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] Instruction,
  output logic [1:0]        rf_rd_addr_a,
  output logic [1:0]        rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_a,
  input  logic [DATA_W-1:0] rf_rd_data_b,
  output logic              rf_we,
  output logic [1:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] operanda,
  output logic [DATA_W-1:0] operandb,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] result,
  input  logic              carry_out,
  input  logic              zero,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              halted
`ifdef CPU_SEQ_TRACE_EN
  ,
  output logic              retire,
  output logic [ADDR_W-1:0] retire_pc
`endif
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              z_flag;
  logic              c_flag;

  logic [7:0] dec_in;
  logic       is_alu;
  logic       is_ld;
  logic       is_st;
  logic       needs_imm;
  logic       is_jmp;
  logic       is_jz;
  logic       is_ldi;
  logic       is_hlt;

  // DECODE must classify the byte arriving from memory before it lands in IR.
  assign dec_in = (state == ST_DECODE) ? Instruction[7:0] : ir[7:0];

  cpu_seq_decode u_decode (
    .insn      (dec_in),
    .is_alu    (is_alu),
    .is_ld     (is_ld),
    .is_st     (is_st),
    .needs_imm (needs_imm),
    .is_jmp    (is_jmp),
    .is_jz     (is_jz),
    .is_ldi    (is_ldi),
    .is_hlt    (is_hlt)
  );

  assign address      = pc;
  assign rf_rd_addr_a = ir[3:2];
  assign rf_rd_addr_b = ir[1:0];
  assign halted       = (state == ST_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    rf_wr_addr = 2'b00;
    rf_wr_data = '0;
    operanda   = '0;
    operandb   = '0;
    alu_op     = 3'b000;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_hlt) begin
          state_next = ST_HALT;
        end else if (needs_imm) begin
          state_next = ST_FETCH_IMM;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_FETCH_IMM: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = run ? ST_FETCH : ST_IDLE;
        if (is_alu) begin
          operanda   = rf_rd_data_a;
          operandb   = rf_rd_data_b;
          alu_op     = ir[6:4];
          rf_we      = 1'b1;
          rf_wr_addr = ir[3:2];
          rf_wr_data = result;
        end else if (is_ld) begin
          dm_addr    = ADDR_W'(rf_rd_data_b);
          dm_re      = 1'b1;
          state_next = ST_MEM;
        end else if (is_st) begin
          dm_addr  = ADDR_W'(rf_rd_data_b);
          dm_wdata = rf_rd_data_a;
          dm_we    = 1'b1;
        end else if (is_ldi) begin
          rf_we      = 1'b1;
          rf_wr_addr = ir[3:2];
          rf_wr_data = Instruction;
        end
      end
      ST_MEM: begin
        rf_we      = 1'b1;
        rf_wr_addr = ir[3:2];
        rf_wr_data = dm_rdata;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // PC/IR/flag updates; in EXEC the memory data bus carries the immediate byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
    end else begin
      case (state)
        ST_DECODE: begin
          ir <= Instruction;
          pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          if (is_alu) begin
            z_flag <= zero;
            c_flag <= carry_out;
          end
          if (is_jmp || (is_jz && z_flag)) begin
            pc <= ADDR_W'(Instruction);
          end else if (is_jz || is_ldi) begin
            pc <= pc + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CPU_SEQ_TRACE_EN
  logic [ADDR_W-1:0] op_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_pc <= RESET_PC;
    end else if (state == ST_DECODE) begin
      op_pc <= pc;
    end
  end

  // HLT retires in its own DECODE cycle, before op_pc has captured it.
  assign retire    = ((state == ST_EXEC) && !is_ld) || (state == ST_MEM) ||
                     ((state == ST_DECODE) && is_hlt);
  assign retire_pc = (state == ST_DECODE) ? pc : op_pc;
`endif

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 8-bit CPU. It owns the program counter, fetches from instruction memory and decodes 8-bit instructions. It steps the ALU, register file and data memory through FETCH/DECODE/EXECUTE/MEM phases. It replaces ad-hoc sequencing between the control unit, PC and execution unit.

Parameters:
ADDR_W, 8, instruction/data address width
DATA_W, 8, datapath width
RESET_PC, 8'h00, PC value after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run  in  1  level enable; sampled at instruction boundaries
address  out  ADDR_W  instruction memory address (= PC)
Instruction  in  DATA_W  instruction memory data, valid 1 cycle after address (sync read)
rf_rd_addr_a  out  2  RF read port A address (= rd)
rf_rd_addr_b  out  2  RF read port B address (= rs)
rf_rd_data_a  in  DATA_W  RF port A data (combinational read)
rf_rd_data_b  in  DATA_W  RF port B data
rf_we  out  1  RF write strobe
rf_wr_addr  out  2  RF write address
rf_wr_data  out  DATA_W  RF write data
operanda  out  DATA_W  ALU operand A
operandb  out  DATA_W  ALU operand B
alu_op  out  3  ALU operation
result  in  DATA_W  ALU result (combinational)
carry_out  in  1  ALU carry
zero  in  1  ALU zero
dm_addr  out  ADDR_W  data memory address
dm_wdata  out  DATA_W  data memory write data
dm_we  out  1  data memory write strobe
dm_re  out  1  data memory read strobe (data valid next cycle)
dm_rdata  in  DATA_W  data memory read data
halted  out  1  high once HLT has executed

Behaviour:
- Instruction format: IR[7:4] opcode, IR[3:2] rd, IR[1:0] rs. Opcodes:
  - 0x0-0x7: ALU, alu_op=IR[6:4], rd <= rd op rs
  - 0x8: LD, rd <= mem[rs]
  - 0x9: ST, mem[rs] <= rd
  - 0xA: JZ imm
  - 0xB: JMP imm
  - 0xC: LDI rd, imm
  - 0xF: HLT
  - 0xD, 0xE: NOP
- imm is the byte following the opcode.
- Reset (async, on reset==0):
  - state=IDLE, PC=RESET_PC, IR=0, Z=0, C=0
  - rf_we=dm_we=dm_re=0, halted=0
  - all data/address outputs 0 except address=RESET_PC
  - Reset mid-instruction aborts it; no write strobe is seen after reset assertion.
- Control outputs are combinational decode of the registered state/IR. Strobes are high exactly one cycle.
- States:
  - IDLE: address=PC. If run, go to FETCH.
  - FETCH: address=PC. Go to DECODE.
  - DECODE: IR<=Instruction; PC<=PC+1. Opcode A/B/C goes to FETCH_IMM; F goes to HALT; else EXEC.
  - FETCH_IMM: address=PC. Go to EXEC.
  - EXEC, by opcode:
    - ALU: operanda=rf_rd_data_a, operandb=rf_rd_data_b; rf_we=1, rf_wr_addr=rd, rf_wr_data=result; Z<=zero, C<=carry_out.
    - LD: dm_addr=rf_rd_data_b, dm_re=1; go to MEM.
    - ST: dm_addr=rf_rd_data_b, dm_wdata=rf_rd_data_a, dm_we=1.
    - LDI: rf_we=1, rf_wr_data=Instruction; PC<=PC+1.
    - JMP: PC<=Instruction.
    - JZ: Z=1 gives PC<=Instruction; Z=0 gives PC<=PC+1.
    - NOP: no strobes.
    - Next state is FETCH if run, else IDLE.
  - MEM: rf_we=1, rf_wr_addr=rd, rf_wr_data=dm_rdata. Next is FETCH if run, else IDLE.
  - HALT: halted=1. Stays until reset; ignores run.
- Latency:
  - ALU/ST/NOP: 3 cycles
  - LD/LDI/JMP/JZ: 4 cycles
  - HLT: 2 cycles to HALT
- Dropping run mid-instruction never aborts; the current instruction completes.
- Flags Z/C change only on ALU ops; LD/LDI leave them untouched.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00. An immediate for an opcode at 0xFF is fetched from 0x00.

Optional Feature:
- Macro CPU_SEQ_TRACE_EN.
- When defined, adds outputs retire (1) and retire_pc (ADDR_W). retire pulses one cycle on the final cycle of every instruction, including HLT's DECODE. retire_pc is that instruction's opcode address.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package cpu_seq_pkg holds:
  - opcode localparams (OP_LD=4'h8, OP_ST, OP_JZ, OP_JMP, OP_LDI, OP_HLT)
  - state encoding (IDLE, FETCH, DECODE, FETCH_IMM, EXEC, MEM, HALT; 3-bit)
  - ALU op codes 000-111
- Sub-module cpu_seq_decode is combinational. It maps IR to is_alu, is_ld, is_st, needs_imm, is_jmp, is_jz, is_ldi, is_hlt.

Test Plan:
- Program LDI r1,0x05; LDI r2,0x03; ADD r1,r2 (0x06) with bench ALU adding: r1 write of 0x08 on cycle 11 after run rises; Z=0.
- SUB r1,r1 then JZ 0x40: ALU zero=1 latches Z; PC=0x40 after EXEC. Repeat with nonzero result: PC advances to opcode address+2.
- ST r1->[r2] then LD r3<-[r2] with r1=0xA5, r2=0x10: dm_we=1 at dm_addr 0x10 with dm_wdata 0xA5; rf_we on r3 with 0xA5 in MEM, 4 cycles after LD FETCH.
- NOP at 0xFF: address wraps to 0x00 on next FETCH. JMP at 0xFF fetches imm from 0x00.
- Drop run during EXEC: instruction completes, FSM parks in IDLE with address=next PC. HLT gives halted=1, which persists with run toggling.
- Assert reset low during LD's MEM cycle: rf_we drops immediately, address=RESET_PC, halted=0, no RF write occurs.
